// File: rtl/uart_time_reporter_pkg.sv
// Shared definitions for the UART time reporter: FSM state codes, ASCII constants,
// the report length default and the BCD digit-pair type.
package uart_time_reporter_pkg;

   localparam int MSG_LEN_DEF = 14;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef logic [7:0] ascii_t;

   localparam ascii_t ASCII_ZERO  = 8'h30;
   localparam ascii_t ASCII_COLON = 8'h3A;
   localparam ascii_t ASCII_DOT   = 8'h2E;
   localparam ascii_t ASCII_CR    = 8'h0D;
   localparam ascii_t ASCII_LF    = 8'h0A;
   localparam ascii_t ASCII_W     = 8'h57;
   localparam ascii_t ASCII_S     = 8'h53;

   localparam logic [6:0] BCD_MAX = 7'd99;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   function automatic ascii_t digit_char(input logic [3:0] d);
      return ASCII_ZERO + ascii_t'(d);
   endfunction

endpackage

// File: rtl/uart_time_reporter_if.sv
// Push/full handshake between the time reporter (master) and the UART TX FIFO (slave).
interface uart_time_reporter_if;
   import uart_time_reporter_pkg::*;

   logic   i_tx_full;
   logic   o_tx_push;
   ascii_t o_tx_data;

   modport master (input i_tx_full, output o_tx_push, output o_tx_data);
   modport slave  (output i_tx_full, input o_tx_push, input o_tx_data);

endinterface

// File: rtl/uart_time_reporter_bin2bcd_99.sv
// Combinational 7-bit binary to two BCD digits; anything above 99 reads as "99".
module bin2bcd_99
   import uart_time_reporter_pkg::*;
(
   input  logic [6:0] bin_i,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   logic sat;

   assign sat    = bin_i > BCD_MAX;
   assign tens_o = sat ? 4'd9 : 4'(bin_i / 7'd10);
   assign ones_o = sat ? 4'd9 : 4'(bin_i % 7'd10);

endmodule

// File: rtl/uart_time_reporter.sv
// Snapshots the watch/stopwatch time on request and streams "<W|S>HH:MM:SS.CC\r\n" into
// the UART TX FIFO. Define UART_TIME_REPORTER_PERIODIC_EN for self-timed reports.
module uart_time_reporter
   import uart_time_reporter_pkg::*;
#(
   parameter int MSG_LEN       = MSG_LEN_DEF,
   parameter int REPORT_PERIOD = 100_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_req,
   input  logic                 i_mode,
   input  logic [4:0]           i_hour,
   input  logic [5:0]           i_min,
   input  logic [5:0]           i_sec,
   input  logic [6:0]           i_csec,
   uart_time_reporter_if.master tx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

   logic [1:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       pending_q, pending_d;
   logic       req;
   logic       mode_q;
   bcd2_t      hour_q, min_q, sec_q, csec_q;
   bcd2_t      hour_d, min_d, sec_d, csec_d;
   ascii_t     byte_sel;
   logic       push;

   bin2bcd_99 u_bcd_hour (.bin_i({2'b00, i_hour}), .tens_o(hour_d.tens), .ones_o(hour_d.ones));
   bin2bcd_99 u_bcd_min  (.bin_i({1'b0, i_min}),   .tens_o(min_d.tens),  .ones_o(min_d.ones));
   bin2bcd_99 u_bcd_sec  (.bin_i({1'b0, i_sec}),   .tens_o(sec_d.tens),  .ones_o(sec_d.ones));
   bin2bcd_99 u_bcd_csec (.bin_i(i_csec),          .tens_o(csec_d.tens), .ones_o(csec_d.ones));

`ifdef UART_TIME_REPORTER_PERIODIC_EN
   localparam int               CNT_W    = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPORT_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign req = i_req | tick;
`else
   assign req = i_req;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      case (state_q)
         ST_IDLE: begin
            if (req || pending_q) begin
               state_d   = ST_LOAD;
               pending_d = 1'b0;
            end
         end
         ST_LOAD: begin
            idx_d   = 4'd0;
            state_d = ST_SEND;
            if (req) pending_d = 1'b1;
         end
         ST_SEND: begin
            if (req) pending_d = 1'b1;
            if (!tx.i_tx_full) begin
               if (idx_q == LAST_IDX) state_d = ST_DONE;
               else                   idx_d   = idx_q + 4'd1;
            end
         end
         default: begin
            // A request landing on the DONE cycle is taken directly instead of via pending.
            if (pending_q) begin
               pending_d = 1'b0;
               state_d   = ST_LOAD;
            end else if (req) begin
               state_d   = ST_LOAD;
            end else begin
               state_d   = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= 4'd0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_LOAD) begin
         mode_q <= i_mode;
         hour_q <= hour_d;
         min_q  <= min_d;
         sec_q  <= sec_d;
         csec_q <= csec_d;
      end
   end

   always_comb begin
      byte_sel = ASCII_LF;
      case (idx_q)
         4'd0:    byte_sel = mode_q ? ASCII_S : ASCII_W;
         4'd1:    byte_sel = digit_char(hour_q.tens);
         4'd2:    byte_sel = digit_char(hour_q.ones);
         4'd3:    byte_sel = ASCII_COLON;
         4'd4:    byte_sel = digit_char(min_q.tens);
         4'd5:    byte_sel = digit_char(min_q.ones);
         4'd6:    byte_sel = ASCII_COLON;
         4'd7:    byte_sel = digit_char(sec_q.tens);
         4'd8:    byte_sel = digit_char(sec_q.ones);
         4'd9:    byte_sel = ASCII_DOT;
         4'd10:   byte_sel = digit_char(csec_q.tens);
         4'd11:   byte_sel = digit_char(csec_q.ones);
         4'd12:   byte_sel = ASCII_CR;
         default: byte_sel = ASCII_LF;
      endcase
   end

   assign push          = (state_q == ST_SEND) && !tx.i_tx_full;
   assign tx.o_tx_push  = push;
   assign tx.o_tx_data  = push ? byte_sel : 8'h00;
   assign o_busy        = (state_q == ST_LOAD) || (state_q == ST_SEND);
   assign o_done        = (state_q == ST_DONE);

endmodule

// File: doc/uart_time_reporter.md
Name: uart_time_reporter

Overview:
- Downstream of the watch/stopwatch datapath; upstream of the UART TX FIFO.
- On a one-cycle request, it snapshots the current time value and formats it as an ASCII line.
- It pushes the line byte-by-byte into the TX FIFO with a push/full handshake.
- This lets a host terminal read the displayed time over the same UART link used for commands.

Parameters:
- MSG_LEN, 14, bytes per report: mode char + "HH:MM:SS.CC" + CR + LF.
- REPORT_PERIOD, 100_000_000, clk cycles between automatic reports (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- i_req  in  1  one-cycle report request (from interpreter/control path).
- i_mode  in  1  0 = watch, 1 = stopwatch; selects the prefix char.
- i_hour  in  5  hours, binary 0..23.
- i_min  in  6  minutes, binary 0..59.
- i_sec  in  6  seconds, binary 0..59.
- i_csec  in  7  centiseconds, binary 0..99.
- i_tx_full  in  1  TX FIFO full.
- o_tx_push  out  1  push strobe, one byte per asserted cycle.
- o_tx_data  out  8  ASCII byte, valid while o_tx_push = 1.
- o_busy  out  1  report in progress.
- o_done  out  1  one-cycle pulse after the last byte is pushed.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, byte index = 0, pending = 0.
  - o_tx_push = 0, o_tx_data = 8'h00, o_busy = 0, o_done = 0.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - i_req = 1 -> LOAD next cycle.
  - o_busy rises in the same cycle as the LOAD entry.
- LOAD (1 cycle):
  - Snapshot i_mode, i_hour, i_min, i_sec and i_csec into registers.
  - Convert each field to tens/ones digits.
  - Byte index = 0. Go to SEND.
- Byte sequence, index 0..13:
  - 0: 'W' (0x57) if mode = 0, else 'S' (0x53).
  - 1-2: hour tens, hour ones.
  - 3: ':'
  - 4-5: minute digits.
  - 6: ':'
  - 7-8: second digits.
  - 9: '.'
  - 10-11: centisecond digits.
  - 12: 0x0D.
  - 13: 0x0A.
  - Digits are 0x30 + value.
- Digit conversion:
  - Any field value > 99 saturates to "99".
  - Values are not range-checked beyond this; hour 24..31 is printed as-is.
- SEND:
  - Each cycle, if i_tx_full = 0: o_tx_push = 1, o_tx_data = byte[index], index increments.
  - If i_tx_full = 1: o_tx_push = 0 and the index holds. No byte is ever dropped or duplicated.
  - Push and data are combinational from the registered state/index gated by ~i_tx_full.
  - After byte 13 is pushed -> DONE.
- DONE (1 cycle):
  - o_done = 1, o_busy = 0.
  - If pending = 1: clear pending and go to LOAD; o_busy re-asserts next cycle.
  - Otherwise go to IDLE.
- Requests while busy (LOAD/SEND/DONE):
  - The first request sets pending.
  - Further requests while pending = 1 are ignored; at most one is queued.
- Input changes during SEND have no effect; only the snapshot is transmitted.
- Minimum latency, i_req to first push = 2 cycles (IDLE -> LOAD -> SEND).
- Full report with no backpressure = 16 cycles from LOAD entry to DONE.
- Reset asserted mid-report: immediate return to IDLE, outputs at reset values, partial line abandoned.

Optional Feature:
- Macro: UART_TIME_REPORTER_PERIODIC_EN.
- Defined:
  - A free-running counter of width $clog2(REPORT_PERIOD) generates an internal request every REPORT_PERIOD cycles.
  - It is ORed with i_req and follows the same pending/ignore rules.
  - The counter resets to 0 on rst.
- Not defined: no counter is instantiated; reports occur only on i_req.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE/ST_LOAD/ST_SEND/ST_DONE;
  - ASCII constants (digit base 0x30, ':', '.', CR, LF, 'W', 'S');
  - the MSG_LEN default.
- One sub-module: bin2bcd_99, purely combinational, 7-bit binary in -> 4-bit tens + 4-bit ones, saturating at 99.
- Four instances are used in LOAD.

Test Plan:
1. Reset release, mode = 0, 13:05:42.07, i_req pulse, full = 0 -> pushes "W13:05:42.07\r\n" on 14 consecutive cycles, starting 2 cycles after i_req; o_done pulses once; o_busy low afterwards.
2. Same request, i_tx_full held high for 5 cycles during byte 4 -> push stalls; the byte stream is unchanged, with no duplicate or missing '0'.
3. mode = 1, 00:00:59.99, i_req, then the inputs change to 01:00:00.00 at byte 3 -> the transmitted line is still "S00:00:59.99\r\n".
4. Three i_req pulses during SEND -> exactly two complete reports, back to back via DONE -> LOAD.
5. rst low at byte 6 -> o_tx_push = 0 immediately; after release, no push occurs until a new i_req.
6. With UART_TIME_REPORTER_PERIODIC_EN defined and REPORT_PERIOD = 50 -> a report starts every 50 cycles with no i_req, each a complete 14-byte line.
